// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state codes, parity mode codes
// and the FIFO entry width helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // FIFO entry layout: {parity_err, frame_err, data}
  function automatic int fifo_entry_width(input int data_bits);
    return data_bits + 2;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO: the head entry is visible on rdata_o whenever
// the FIFO is non-empty; a push into a full FIFO is accepted only alongside a pop.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       wdata_i,
  output logic [WIDTH-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign count_o = count_q;
  // Gate the head so the data output reads zero while empty.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with 3-sample majority voting and a show-ahead FIFO.
// Parity checking is built only when UART_RX_PARITY_EN is defined.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OSR         = 16,
  parameter int STOP_BITS   = 1,
  parameter int PARITY_MODE = 0,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rx_tick,
  input  logic                        uart_rx_in,
  output logic [DATA_BITS-1:0]        rx_data_out,
  output logic                        rx_data_valid,
  input  logic                        rx_data_ready,
  output logic                        frame_err,
  output logic                        parity_err,
  output logic                        overrun_err,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int EW  = fifo_entry_width(DATA_BITS);
  localparam int TW  = $clog2(OSR);
  localparam int M   = OSR / 2;
  localparam int BCW = 4;
`ifdef UART_RX_PARITY_EN
  localparam int PMODE = PARITY_MODE;
`else
  localparam int PMODE = PARITY_MODE - PARITY_MODE;
`endif
  localparam bit PAR_EN = (PMODE != PARITY_NONE);

  rx_state_e            state_q, state_d;
  logic                 sync1_q, line_q;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           vote_q, vote_d;
  logic                 frm_q, frm_d;
  logic                 armed_q, armed_d;
  logic                 overrun_q;
  logic                 push, pop, fifo_full, fifo_empty;
  logic                 par_bit;
  logic                 bit_end, vote_now, voted;
  logic [EW-1:0]        push_word, head_word;

  assign bit_end  = rx_tick && (tick_cnt_q == TW'(OSR - 1));
  assign vote_now = rx_tick && (tick_cnt_q == TW'(M + 1));
  assign voted    = (vote_q[0] & vote_q[1]) | (vote_q[0] & line_q) | (vote_q[1] & line_q);

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  logic exp_par;
  assign exp_par = (^shift_q) ^ (PMODE == PARITY_ODD);
  assign par_bit = par_d;
`else
  assign par_bit = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    vote_d     = vote_q;
    frm_d      = frm_q;
    armed_d    = armed_q | line_q;
    push       = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d      = par_q;
`endif
    if (state_q != ST_IDLE && rx_tick) begin
      tick_cnt_d = bit_end ? '0 : tick_cnt_q + 1'b1;
      if (tick_cnt_q == TW'(M - 1)) vote_d[0] = line_q;
      if (tick_cnt_q == TW'(M))     vote_d[1] = line_q;
    end
    case (state_q)
      ST_IDLE: begin
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
        frm_d      = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d      = 1'b0;
`endif
        if (!line_q && armed_q) state_d = ST_START;
      end
      ST_START: begin
        if (vote_now && voted) state_d = ST_IDLE;
        else if (bit_end)      state_d = ST_DATA;
      end
      ST_DATA: begin
        if (vote_now) shift_d = {voted, shift_q[DATA_BITS-1:1]};
        if (bit_end) begin
          if (bit_cnt_q == BCW'(DATA_BITS - 1)) begin
            bit_cnt_d = '0;
            state_d   = PAR_EN ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (vote_now && (voted != exp_par)) par_d = 1'b1;
        if (bit_end) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (vote_now) begin
          if (!voted) frm_d = 1'b1;
          // Leave at mid-bit so the next start edge is caught promptly; a low
          // stop bit (break) must see the line return high before re-arming.
          if (bit_cnt_q == BCW'(STOP_BITS - 1)) begin
            push    = 1'b1;
            state_d = ST_IDLE;
            if (!voted) armed_d = 1'b0;
          end
        end
        if (bit_end) bit_cnt_d = bit_cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= 1'b1;
      line_q     <= 1'b1;
      state_q    <= ST_IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      vote_q     <= '0;
      frm_q      <= 1'b0;
      armed_q    <= 1'b1;
      overrun_q  <= 1'b0;
    end else begin
      sync1_q    <= uart_rx_in;
      line_q     <= sync1_q;
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      vote_q     <= vote_d;
      frm_q      <= frm_d;
      armed_q    <= armed_d;
      overrun_q  <= push && fifo_full && !pop;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= par_d;
  end
`endif

  assign push_word = {par_bit, frm_d, shift_q};
  assign pop       = rx_data_valid && rx_data_ready;

  uart_rx_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (push_word),
    .rdata_o (head_word),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign rx_data_valid = !fifo_empty;
  assign rx_data_out   = head_word[DATA_BITS-1:0];
  assign frame_err     = head_word[DATA_BITS];
  assign parity_err    = head_word[DATA_BITS+1];
  assign overrun_err   = overrun_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: stimulus pushes expected words, a monitor
// pops and compares whenever a word is consumed. Exercises parity if UART_RX_PARITY_EN.
module tb_uart_rx_param;

  localparam int DB  = 8;
  localparam int OSR = 16;
  localparam int FD  = 4;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          rx_tick = 1'b0;
  logic          uart_rx_in = 1'b1;
  logic          rx_data_ready = 1'b0;
  logic [DB-1:0] rx_data_out;
  logic          rx_data_valid;
  logic          frame_err;
  logic          parity_err;
  logic          overrun_err;
  logic [$clog2(FD):0] fifo_count;

  uart_rx_param #(
    .DATA_BITS   (DB),
    .OSR         (OSR),
    .STOP_BITS   (1),
    .PARITY_MODE (2),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_tick       (rx_tick),
    .uart_rx_in    (uart_rx_in),
    .rx_data_out   (rx_data_out),
    .rx_data_valid (rx_data_valid),
    .rx_data_ready (rx_data_ready),
    .frame_err     (frame_err),
    .parity_err    (parity_err),
    .overrun_err   (overrun_err),
    .fifo_count    (fifo_count)
  );

  always #5 clk = ~clk;

  // rx_tick: one clock high out of every two
  initial begin
    forever begin
      @(negedge clk) rx_tick = 1'b1;
      @(negedge clk) rx_tick = 1'b0;
    end
  end

  typedef struct packed {
    logic [DB-1:0] data;
    logic          frm;
    logic          par;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   ovr_cnt = 0;
  int   rx_cnt = 0;
  int   exp_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  task automatic expect_word(input logic [DB-1:0] d, input logic f, input logic p);
    exp_t e;
    e.data = d;
    e.frm  = f;
    e.par  = p;
    exp_q.push_back(e);
    exp_total++;
  endtask

  task automatic ticks(input int n);
    repeat (2 * n) @(negedge clk);
  endtask

  task automatic send_bit(input logic v);
    uart_rx_in = v;
    ticks(OSR);
  endtask

  // glitch >= 0 inverts that data bit for one tick around mid-bit
  task automatic send_frame(input logic [DB-1:0] d, input logic stop_v, input int glitch,
                            input logic par_flip);
    send_bit(1'b0);
    for (int i = 0; i < DB; i++) begin
      if (i == glitch) begin
        uart_rx_in = d[i];
        ticks(9);
        uart_rx_in = ~d[i];
        ticks(1);
        uart_rx_in = d[i];
        ticks(OSR - 10);
      end else begin
        send_bit(d[i]);
      end
    end
    if (PAR_ON) send_bit((^d) ^ par_flip);
    send_bit(stop_v);
    uart_rx_in = 1'b1;
    ticks(2 * OSR);
  endtask

  task automatic wait_drain(input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
  endtask

  // Monitor: sample just after the negedge, i.e. the values seen by the next posedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (overrun_err) ovr_cnt++;
      if (rst_n && rx_data_valid && rx_data_ready) begin
        rx_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=%0h required=none", rx_data_out);
        end else begin
          e = exp_q.pop_front();
          check("word_data", rx_data_out, e.data);
          check("word_frame_err", frame_err, e.frm);
          check("word_parity_err", parity_err, e.par);
        end
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_data"}, rx_data_out, 0);
    check({tag, "_valid"}, rx_data_valid, 0);
    check({tag, "_frame"}, frame_err, 0);
    check({tag, "_parity"}, parity_err, 0);
    check({tag, "_overrun"}, overrun_err, 0);
    check({tag, "_count"}, fifo_count, 0);
  endtask

  initial begin
    logic [DB-1:0] d;
    int ovr0, cnt0;

    #2 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    rx_data_ready = 1'b1;
    ticks(4);

    // Basic 8N1 frame
    expect_word(8'hA5, 1'b0, 1'b0);
    send_frame(8'hA5, 1'b1, -1, 1'b0);
    wait_drain(200);
    check("a5_count_back_to_0", fifo_count, 0);

    // False start then a good frame
    cnt0 = rx_cnt;
    uart_rx_in = 1'b0;
    ticks(4);
    uart_rx_in = 1'b1;
    ticks(3 * OSR);
    check("false_start_valid", rx_data_valid, 0);
    check("false_start_no_word", rx_cnt - cnt0, 0);
    expect_word(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b1, -1, 1'b0);
    wait_drain(200);

    // Low stop bit, then a clean frame
    expect_word(8'h81, 1'b1, 1'b0);
    send_frame(8'h81, 1'b0, -1, 1'b0);
    expect_word(8'h55, 1'b0, 1'b0);
    send_frame(8'h55, 1'b1, -1, 1'b0);
    wait_drain(200);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x03 has an even number of ones, so parity bit 1 is wrong
    expect_word(8'h03, 1'b0, 1'b1);
    send_frame(8'h03, 1'b1, -1, 1'b1);
    expect_word(8'h03, 1'b0, 1'b0);
    send_frame(8'h03, 1'b1, -1, 1'b0);
    wait_drain(200);
`endif

    // Line held low for a whole frame (break), then a clean frame
    expect_word(8'h00, 1'b1, 1'b0);
    uart_rx_in = 1'b0;
    ticks((DB + 2 + (PAR_ON ? 1 : 0)) * OSR);
    uart_rx_in = 1'b1;
    ticks(2 * OSR);
    wait_drain(200);
    expect_word(8'h55, 1'b0, 1'b0);
    send_frame(8'h55, 1'b1, -1, 1'b0);
    wait_drain(200);

    // Overrun: fill the FIFO with ready low; fifth word is dropped
    rx_data_ready = 1'b0;
    ovr0 = ovr_cnt;
    for (int k = 1; k <= 5; k++) begin
      d = DB'(k * 'h11);
      if (k < 5) expect_word(d, 1'b0, 1'b0);
      send_frame(d, 1'b1, -1, 1'b0);
    end
    check("overrun_count_full", fifo_count, FD);
    check("overrun_pulses", ovr_cnt - ovr0, 1);
    check("overrun_head", rx_data_out, 8'h11);
    rx_data_ready = 1'b1;
    wait_drain(200);
    check("overrun_count_empty", fifo_count, 0);

    // Reset during data bit 3 with a word already buffered
    rx_data_ready = 1'b0;
    send_frame(8'h99, 1'b1, -1, 1'b0);
    check("pre_reset_count", fifo_count, 1);
    d = 8'hC3;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(d[i]);
    uart_rx_in = d[3];
    ticks(8);
    rst_n = 1'b0;
    #1 check_all_zero("midframe_reset");
    @(negedge clk);
    uart_rx_in = 1'b1;
    ticks(4);
    rst_n = 1'b1;
    ticks(OSR);
    rx_data_ready = 1'b1;
    expect_word(8'hC3, 1'b0, 1'b0);
    send_frame(8'hC3, 1'b1, -1, 1'b0);
    wait_drain(200);

    // Single-tick glitch at mid-bit is outvoted
    expect_word(8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1, 3, 1'b0);
    expect_word(8'h5A, 1'b0, 1'b0);
    send_frame(8'h5A, 1'b1, 0, 1'b0);
    wait_drain(200);

    check("total_words", rx_cnt, exp_total);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
